// File: rtl/video_cap_pkg.sv
// Shared types and default geometry for the defog video capture sink and its stream source.
package video_cap_pkg;

   localparam int H_ACTIVE_DEF   = 1280;
   localparam int V_ACTIVE_DEF   = 720;
   localparam int FIFO_DEPTH_DEF = 16;
   localparam int ADDR_W_DEF     = 32;
   localparam int PIX_W          = 24;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      ACTIVE    = 2'd1,
      DRAIN     = 2'd2
   } cap_state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

endpackage

// File: rtl/video_frame_capture_if.sv
// Video input stream plus the addressed pixel-write handshake toward the frame buffer.
interface video_frame_capture_if
   import video_cap_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              hsync;
   logic              vsync;
   logic              en;
   logic [7:0]        r;
   logic [7:0]        g;
   logic [7:0]        b;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;

   // master is the capture block: it consumes video and issues writes.
   modport master (
      input  hsync, vsync, en, r, g, b, wr_ready,
      output wr_valid, wr_addr, wr_data
   );

   modport slave (
      output hsync, vsync, en, r, g, b, wr_ready,
      input  wr_valid, wr_addr, wr_data
   );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees a slot for a same-cycle push when full.
module sync_fifo
   import video_cap_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int WIDTH = ADDR_W_DEF + PIX_W
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   // Head is forced to zero while empty so the write port idles at a known value.
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      // NOTE: clocked state uses <= so every register samples pre-edge values.
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/video_frame_capture.sv
// Turns hsync/vsync/en raster video into addressed frame-buffer writes with per-frame geometry checks.
// Define CAPTURE_BOTTOM_UP_EN for BMP bottom-up row order; default is linear top-down addressing.
module video_frame_capture
   import video_cap_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int ADDR_W     = ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  nrst,
   video_frame_capture_if.master bus,
   output logic                  frame_done,
   output logic [11:0]           frame_cnt,
   output logic                  line_err,
   output logic                  ovf
);
   // Counters saturate one past the nominal size so overlong lines/frames stay distinguishable.
   localparam int CW = $clog2(H_ACTIVE + 2);
   localparam int LW = $clog2(V_ACTIVE + 2);
   localparam logic [CW-1:0]     COL_END  = CW'(H_ACTIVE);
   localparam logic [CW-1:0]     COL_SAT  = CW'(H_ACTIVE + 1);
   localparam logic [LW-1:0]     LINE_END = LW'(V_ACTIVE);
   localparam logic [LW-1:0]     LINE_SAT = LW'(V_ACTIVE + 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE);
`ifdef CAPTURE_BOTTOM_UP_EN
   localparam bit                BOTTOM_UP = 1'b1;
   localparam logic [ADDR_W-1:0] ROW_BASE0 = ADDR_W'((V_ACTIVE - 1) * H_ACTIVE);
`else
   localparam bit                BOTTOM_UP = 1'b0;
   localparam logic [ADDR_W-1:0] ROW_BASE0 = '0;
`endif

   cap_state_t        state;
   cap_state_t        state_nxt;
   logic              vsync_q;
   logic [CW-1:0]     col;
   logic [LW-1:0]     line;
   logic [ADDR_W-1:0] row_base;
   logic              line_open;
   logic              line_err_q;
   logic              ovf_q;
   logic              frame_done_q;
   logic [11:0]       frame_cnt_q;

   logic              vs_fall;
   logic              pix_act;
   logic              in_range;
   logic              can_push;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     col_pix;
   logic              open_now;
   logic              line_end;
   logic [LW-1:0]     line_after;
   logic [ADDR_W-1:0] row_base_nxt;
   logic              err_set;
   logic              ovf_set;
   logic              frame_end;
   logic              clear_cnt;
   logic              frame_err;
   pixel_t            pix;
   logic [ADDR_W+PIX_W-1:0] fifo_dout;

   assign pix      = '{r: bus.r, g: bus.g, b: bus.b};
   assign vs_fall  = vsync_q & ~bus.vsync;
   assign pix_act  = (state == ACTIVE) & bus.en;
   assign in_range = (col < COL_END) & (line < LINE_END);
   assign pop      = ~fifo_empty & bus.wr_ready;
   assign can_push = ~fifo_full | pop;
   assign push     = pix_act & in_range & can_push;

   // col_pix counts the current pixel, so a line cut by vsync while en=1 still includes it.
   assign col_pix    = (pix_act && col != COL_SAT) ? col + 1'b1 : col;
   assign open_now   = line_open | pix_act;
   assign line_end   = (state == ACTIVE) & ((line_open & ~bus.en) | (vs_fall & open_now));
   assign line_after = (line_end && line != LINE_SAT) ? line + 1'b1 : line;
   assign row_base_nxt = BOTTOM_UP ? row_base - ROW_STEP : row_base + ROW_STEP;

   assign err_set = (pix_act & ~in_range) | (line_end & (col_pix != COL_END)) | frame_err;
   assign ovf_set = (pix_act & in_range & ~can_push) | ((state == DRAIN) & bus.en);

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nxt = state;
      frame_end = 1'b0;
      clear_cnt = 1'b0;
      frame_err = 1'b0;
      case (state)
         WAIT_SYNC: begin
            if (vs_fall) begin
               state_nxt = ACTIVE;
               clear_cnt = 1'b1;
            end
         end
         ACTIVE: begin
            if (vs_fall) begin
               state_nxt = DRAIN;
               frame_err = (line_after != LINE_END);
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               state_nxt = ACTIVE;
               frame_end = 1'b1;
               clear_cnt = 1'b1;
            end
         end
         default: state_nxt = WAIT_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) state <= WAIT_SYNC;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         vsync_q      <= 1'b0;
         col          <= '0;
         line         <= '0;
         row_base     <= ROW_BASE0;
         line_open    <= 1'b0;
         line_err_q   <= 1'b0;
         ovf_q        <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         vsync_q <= bus.vsync;
         if (clear_cnt) begin
            col       <= '0;
            line      <= '0;
            row_base  <= ROW_BASE0;
            line_open <= 1'b0;
         end else if (state == ACTIVE) begin
            col       <= line_end ? '0 : col_pix;
            line      <= line_after;
            line_open <= open_now & ~line_end;
            if (line_end) row_base <= row_base_nxt;
         end
         // Flags describe the frame just reported; they restart the cycle after frame_done.
         line_err_q   <= (line_err_q & ~frame_done_q) | err_set;
         ovf_q        <= (ovf_q & ~frame_done_q) | ovf_set;
         frame_done_q <= frame_end;
         if (frame_end) frame_cnt_q <= frame_cnt_q + 1'b1;
      end
   end

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + PIX_W)
   ) u_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (push),
      .din   ({row_base + ADDR_W'(col), pix}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.wr_valid = ~fifo_empty;
   assign bus.wr_addr  = fifo_dout[ADDR_W+PIX_W-1:PIX_W];
   assign bus.wr_data  = fifo_dout[PIX_W-1:0];

   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;
   assign line_err   = line_err_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_video_frame_capture.sv
// Scoreboard bench for video_frame_capture: expected writes and frame results are queued at stimulus time.
module tb_video_frame_capture;
   import video_cap_pkg::*;

   localparam int H     = 8;
   localparam int V     = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        frame_done;
   logic [11:0] frame_cnt;
   logic        line_err;
   logic        ovf;

   video_frame_capture_if #(.ADDR_W(AW)) bus ();

   video_frame_capture #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .FIFO_DEPTH (DEPTH),
      .ADDR_W     (AW)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .bus        (bus),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .line_err   (line_err),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [23:0]   data;
   } wr_exp_t;

   typedef struct packed {
      logic [11:0] cnt;
      logic        err;
      logic        ov;
   } frame_exp_t;

   wr_exp_t    wr_q[$];
   frame_exp_t frame_q[$];
   int         checks = 0;
   int         failures = 0;
   int         frames_seen = 0;
   logic [11:0] exp_cnt = '0;
   logic        stall_prev = 1'b0;
   logic [AW+23:0] stall_word = '0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] exp_addr(input int ln, input int c);
`ifdef CAPTURE_BOTTOM_UP_EN
      return AW'((V - 1 - ln) * H + c);
`else
      return AW'(ln * H + c);
`endif
   endfunction

   // Output monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin : monitor
      wr_exp_t    e;
      frame_exp_t f;
      if (!nrst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            check("stall_hold", {bus.wr_valid, bus.wr_addr, bus.wr_data}, {1'b1, stall_word});
         if (bus.wr_valid && bus.wr_ready) begin
            check("write_expected", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) begin
               e = wr_q.pop_front();
               check("wr_addr", bus.wr_addr, e.addr);
               check("wr_data", bus.wr_data, e.data);
            end
         end
         stall_prev = bus.wr_valid && !bus.wr_ready;
         stall_word = {bus.wr_addr, bus.wr_data};
         if (frame_done) begin
            frames_seen++;
            check("writes_drained", wr_q.size(), 0);
            check("frame_expected", frame_q.size() != 0, 1);
            if (frame_q.size() != 0) begin
               f = frame_q.pop_front();
               check("frame_cnt", frame_cnt, f.cnt);
               check("line_err", line_err, f.err);
               check("ovf", ovf, f.ov);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.en = 1'b0;
      repeat (n) tick();
   endtask

   task automatic vsync_fall();
      bus.en    = 1'b0;
      bus.vsync = 1'b1;
      tick();
      tick();
      bus.vsync = 1'b0;
      tick();
   endtask

   task automatic drive_pixels(input int ln, input int npix, input int nstore);
      logic [23:0] d;
      for (int c = 0; c < npix; c++) begin
         d = 24'($urandom);
         bus.en    = 1'b1;
         bus.hsync = 1'b1;
         {bus.r, bus.g, bus.b} = d;
         if (c < nstore) wr_q.push_back({exp_addr(ln, c), d});
         tick();
      end
   endtask

   task automatic send_line(input int ln, input int npix, input int nstore);
      drive_pixels(ln, npix, nstore);
      bus.hsync = 1'b0;
      idle(3);
   endtask

   task automatic clean_frame();
      for (int l = 0; l < V; l++) send_line(l, H, H);
   endtask

   task automatic end_frame(input logic err, input logic ov);
      int start;
      start = frames_seen;
      exp_cnt++;
      frame_q.push_back({exp_cnt, err, ov});
      vsync_fall();
      for (int i = 0; i < 100 && frames_seen == start; i++) tick();
      check("frame_done_seen", frames_seen - start, 1);
      check("frame_done_pulse", frame_done, 0);
      check("line_err_cleared", line_err, 0);
      check("ovf_cleared", ovf, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_valid"}, bus.wr_valid, 0);
      check({tag, "_wr_addr"}, bus.wr_addr, 0);
      check({tag, "_wr_data"}, bus.wr_data, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_frame_cnt"}, frame_cnt, 0);
      check({tag, "_line_err"}, line_err, 0);
      check({tag, "_ovf"}, ovf, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.hsync    = 1'b0;
      bus.vsync    = 1'b0;
      bus.en       = 1'b0;
      bus.r        = '0;
      bus.g        = '0;
      bus.b        = '0;
      bus.wr_ready = 1'b1;
      nrst         = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      nrst = 1'b1;
      tick();

      // Pixels before the first vsync fall are ignored.
      drive_pixels(0, 5, 0);
      idle(4);
      check("presync_frame_cnt", frame_cnt, 0);
      check("presync_wr_valid", bus.wr_valid, 0);

      vsync_fall();
      clean_frame();
      end_frame(1'b0, 1'b0);

      // Short line 2: 31 writes, geometry error reported.
      send_line(0, H, H);
      send_line(1, H, H);
      send_line(2, H - 1, H - 1);
      send_line(3, H, H);
      end_frame(1'b1, 1'b0);

      clean_frame();
      end_frame(1'b0, 1'b0);

      // Memory stalls for a whole line: FIFO holds DEPTH pixels, the rest drop.
      bus.wr_ready = 1'b0;
      send_line(0, H, DEPTH);
      check("bp_ovf_live", ovf, 1);
      check("bp_wr_valid", bus.wr_valid, 1);
      bus.wr_ready = 1'b1;
      for (int l = 1; l < V; l++) send_line(l, H, H);
      end_frame(1'b0, 1'b1);

      // Reset in the middle of a stalled frame.
      bus.wr_ready = 1'b0;
      send_line(0, H, 0);
      drive_pixels(1, 2, 0);
      check("pre_reset_ovf", ovf, 1);
      bus.en = 1'b0;
      nrst   = 1'b0;
      tick();
      check_reset_outputs("midreset");
      bus.wr_ready = 1'b1;
      tick();
      nrst    = 1'b1;
      exp_cnt = '0;
      idle(5);
      check("post_reset_wr_valid", bus.wr_valid, 0);
      check("post_reset_frame_cnt", frame_cnt, 0);

      vsync_fall();
      clean_frame();
      end_frame(1'b0, 1'b0);

      idle(5);
      check("final_wr_queue", wr_q.size(), 0);
      check("final_frame_queue", frame_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
